alu_seq_bank: RTL and testbench

//  Parametrised sequential ALU. Accepts one instruction plus two operands per handshake,

---
 rtl/alu_seq_bank.sv | 187 ++++++++++++++++++
 tb/tb_alu_seq_bank.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq_bank.sv
// rtl/alu_seq_bank.sv - sequential ALU writing results into a bank of registered output lanes
//
// Purpose: accepts one instruction plus two operands per valid/ready handshake.
// Single-cycle ops retire on the edge after acceptance. MUL is a shift-add
// multiplier that consumes one multiplier bit per cycle and retires W edges
// after acceptance.
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   in_valid, in_ready   instruction handshake; in_ready is high only while idle
//   instruction[15:12]   opcode
//   instruction[11:8]    destination lane (low log2(NOUT) bits used)
//   data0, data1         operands A and B
//   out_bus              NOUT lanes of W bits; lane i = out_bus[i*W +: W]
//   done, illegal        one-cycle pulses when an op retires / retires undefined
//   zero_flag, carry_flag, overflow   flags of the last retired defined op
module alu_seq_bank #(
  parameter int W    = 8,
  parameter int NOUT = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [15:0]     instruction,
  input  logic [W-1:0]    data0,
  input  logic [W-1:0]    data1,
  output logic [W*NOUT-1:0] out_bus,
  output logic            done,
  output logic            zero_flag,
  output logic            carry_flag,
  output logic            overflow,
  output logic            illegal
);

  localparam int LW = $clog2(NOUT);
  localparam int SW = $clog2(W);

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_XOR = 4'd4;
  localparam logic [3:0] OP_SHL = 4'd5;
  localparam logic [3:0] OP_MUL = 4'd6;
  localparam logic [3:0] OP_CMP = 4'd7;

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXEC,
    S_MUL
  } state_t;

  state_t          state;
  logic [3:0]      op_q;
  logic [LW-1:0]   dst_q;
  logic [W-1:0]    a_q;
  logic [W-1:0]    b_q;       // operand B; doubles as the shifting multiplier in MUL
  logic [2*W-1:0]  mcand_q;   // multiplicand, shifted left one place per MUL step
  logic [2*W-1:0]  acc_q;
  logic [SW-1:0]   cnt_q;
  logic [W-1:0]    lanes [NOUT];

  // Reserved instruction bits and the unused upper dst bits are deliberately ignored.
  logic unused_instr;
  assign unused_instr = ^instruction;

  assign in_ready = (state == S_IDLE);

  for (genvar i = 0; i < NOUT; i++) begin : g_lane
    assign out_bus[i*W +: W] = lanes[i];
  end

  // Result and flags of the single-cycle ops, from the captured operands.
  logic [W:0]   sum;
  logic [W:0]   diff;
  logic [W:0]   shl;
  logic [W-1:0] ex_res;
  logic         ex_c;
  logic         ex_v;
  logic         ex_wr;
  logic         ex_legal;

  always_comb begin
    sum      = {1'b0, a_q} + {1'b0, b_q};
    diff     = {1'b0, a_q} - {1'b0, b_q};
    // Bit W of the widened shift is the last bit pushed out of A (0 for amount 0).
    shl      = {1'b0, a_q} << b_q[SW-1:0];
    ex_res   = '0;
    ex_c     = 1'b0;
    ex_v     = 1'b0;
    ex_wr    = 1'b1;
    ex_legal = 1'b1;
    case (op_q)
      OP_ADD: begin
        ex_res = sum[W-1:0];
        ex_c   = sum[W];
        ex_v   = (a_q[W-1] == b_q[W-1]) && (sum[W-1] != a_q[W-1]);
      end
      OP_SUB, OP_CMP: begin
        ex_res = diff[W-1:0];
        ex_c   = diff[W];
        ex_v   = (a_q[W-1] != b_q[W-1]) && (diff[W-1] != a_q[W-1]);
        ex_wr  = (op_q == OP_SUB);
      end
      OP_AND: ex_res = a_q & b_q;
      OP_OR:  ex_res = a_q | b_q;
      OP_XOR: ex_res = a_q ^ b_q;
      OP_SHL: begin
        ex_res = shl[W-1:0];
        ex_c   = shl[W];
      end
      default: begin
        ex_wr    = 1'b0;
        ex_legal = 1'b0;
      end
    endcase
  end

  // One shift-add step: add the multiplicand when the current multiplier bit is set.
  logic [2*W-1:0] acc_nxt;
  assign acc_nxt = acc_q + (b_q[0] ? mcand_q : '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      op_q       <= '0;
      dst_q      <= '0;
      a_q        <= '0;
      b_q        <= '0;
      mcand_q    <= '0;
      acc_q      <= '0;
      cnt_q      <= '0;
      done       <= 1'b0;
      illegal    <= 1'b0;
      zero_flag  <= 1'b0;
      carry_flag <= 1'b0;
      overflow   <= 1'b0;
      for (int i = 0; i < NOUT; i++) lanes[i] <= '0;
    end else begin
      done    <= 1'b0;
      illegal <= 1'b0;
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            op_q    <= instruction[15:12];
            dst_q   <= instruction[8 +: LW];
            a_q     <= data0;
            b_q     <= data1;
            mcand_q <= {{W{1'b0}}, data0};
            acc_q   <= '0;
            cnt_q   <= '0;
            state   <= (instruction[15:12] == OP_MUL) ? S_MUL : S_EXEC;
          end
        end
        S_EXEC: begin
          done <= 1'b1;
          if (ex_legal) begin
            zero_flag  <= (ex_res == '0);
            carry_flag <= ex_c;
            overflow   <= ex_v;
          end else begin
            illegal <= 1'b1;
          end
          if (ex_wr) lanes[dst_q] <= ex_res;
          state <= S_IDLE;
        end
        S_MUL: begin
          acc_q   <= acc_nxt;
          mcand_q <= mcand_q << 1;
          b_q     <= b_q >> 1;
          cnt_q   <= cnt_q + 1'b1;
          if (cnt_q == SW'(W - 1)) begin
            lanes[dst_q] <= acc_nxt[W-1:0];
            zero_flag    <= (acc_nxt[W-1:0] == '0);
            carry_flag   <= 1'b0;
            overflow     <= |acc_nxt[2*W-1:W];
            done         <= 1'b1;
            state        <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq_bank.sv
// tb/tb_alu_seq_bank.sv - randomized self-checking bench for alu_seq_bank
module tb_alu_seq_bank;

  localparam int W    = 8;
  localparam int NOUT = 4;
  localparam int M    = 1 << W;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic [15:0]       instruction;
  logic [W-1:0]      data0;
  logic [W-1:0]      data1;
  logic [W*NOUT-1:0] out_bus;
  logic              done;
  logic              zero_flag;
  logic              carry_flag;
  logic              overflow;
  logic              illegal;

  alu_seq_bank #(.W(W), .NOUT(NOUT)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .instruction (instruction),
    .data0       (data0),
    .data1       (data1),
    .out_bus     (out_bus),
    .done        (done),
    .zero_flag   (zero_flag),
    .carry_flag  (carry_flag),
    .overflow    (overflow),
    .illegal     (illegal)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  // Reference state: lane contents and flags of the last retired defined op.
  int m_lane [NOUT];
  bit m_z, m_c, m_v;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W*NOUT-1:0] exp_bus();
    logic [W*NOUT-1:0] r;
    for (int i = 0; i < NOUT; i++) r[i*W +: W] = W'(m_lane[i]);
    return r;
  endfunction

  function automatic int sgn(input int x);
    return (x >= M / 2) ? x - M : x;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NOUT; i++) m_lane[i] = 0;
    m_z = 0; m_c = 0; m_v = 0;
  endtask

  task automatic model_op(input int op, input int dst, input int a, input int b, output bit ill);
    int r;
    int s;
    int amt;
    bit wr;
    r   = 0;
    wr  = 1;
    ill = 0;
    case (op)
      0: begin
        r = a + b; m_c = (r >= M);
        s = sgn(a) + sgn(b); m_v = (s > M / 2 - 1) || (s < -M / 2);
        r = r % M;
      end
      1, 7: begin
        r = a - b; m_c = (a < b);
        s = sgn(a) - sgn(b); m_v = (s > M / 2 - 1) || (s < -M / 2);
        r = (r + M) % M;
        wr = (op == 1);
      end
      2: begin r = a & b; m_c = 0; m_v = 0; end
      3: begin r = a | b; m_c = 0; m_v = 0; end
      4: begin r = a ^ b; m_c = 0; m_v = 0; end
      5: begin
        amt = b % W;
        r = (a << amt) % M;
        m_c = (amt == 0) ? 1'b0 : 1'((a >> (W - amt)) & 1);
        m_v = 0;
      end
      6: begin
        r = a * b; m_v = (r >= M); m_c = 0;
        r = r % M;
      end
      default: begin ill = 1; wr = 0; end
    endcase
    if (!ill) begin
      m_z = (r == 0);
      if (wr) m_lane[dst % NOUT] = r;
    end
  endtask

  // Issue one op, hold garbage on the inputs while busy, and check the retirement.
  task automatic run_op(input int op, input int dst, input int a, input int b);
    int lat;
    int exp_lat;
    bit ill;
    bit fin;
    @(negedge clk);
    check("ready_idle", in_ready, 1);
    in_valid    = 1;
    instruction = {op[3:0], dst[3:0], 8'($urandom)};
    data0       = a[W-1:0];
    data1       = b[W-1:0];
    @(posedge clk);
    model_op(op, dst, a, b, ill);
    exp_lat = (op == 6) ? W : 1;
    lat = 0;
    fin = 0;
    while (!fin) begin
      @(negedge clk);
      if (done) begin
        fin = 1;
      end else if (lat > 40) begin
        check("done_timeout", lat, exp_lat);
        fin = 1;
      end else begin
        check("busy_ready", in_ready, 0);
        in_valid    = 1;
        instruction = 16'($urandom);
        data0       = W'($urandom);
        data1       = W'($urandom);
        @(posedge clk);
        lat++;
      end
    end
    in_valid = 0;
    check("latency", lat, exp_lat);
    check("illegal", illegal, ill);
    check("out_bus", out_bus, exp_bus());
    check("zero", zero_flag, m_z);
    check("carry", carry_flag, m_c);
    check("ovf", overflow, m_v);
    @(negedge clk);
    check("done_pulse", done, 0);
    check("illegal_pulse", illegal, 0);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_bus"}, out_bus, 0);
    check({tag, "_flags"}, {zero_flag, carry_flag, overflow}, 0);
    check({tag, "_ready"}, in_ready, 1);
    check({tag, "_done"}, done, 0);
    check({tag, "_illegal"}, illegal, 0);
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      in_valid    = 0;
      instruction = 16'($urandom);
      data0       = W'($urandom);
      data1       = W'($urandom);
      check("idle_done", done, 0);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int op;
    rst_n       = 0;
    in_valid    = 0;
    instruction = '0;
    data0       = '0;
    data1       = '0;
    model_reset();
    repeat (2) @(negedge clk);
    check_reset_state("reset");
    rst_n = 1;

    // Directed cases
    run_op(0, 2, 8'hFF, 8'h01);
    run_op(0, 0, 8'h7F, 8'h01);
    run_op(1, 1, 8'h01, 8'h03);
    run_op(6, 3, 8'h10, 8'h10);
    run_op(6, 1, 8'h0F, 8'h03);
    run_op(5, 2, 8'h81, 8'h01);
    run_op(5, 0, 8'h81, 8'h08);
    run_op(7, 0, 8'h05, 8'h05);
    run_op(15, 2, 8'h12, 8'h34);
    run_op(0, 14, 8'h11, 8'h22);
    idle_cycles(3);

    // Asynchronous reset in the middle of a cycle with non-zero lanes
    @(posedge clk);
    #3 rst_n = 0;
    #1;
    model_reset();
    check_reset_state("async_reset");
    @(negedge clk);
    rst_n = 1;

    run_op(0, 1, 8'h40, 8'h40);

    // Reset asserted three cycles into a MUL
    @(negedge clk);
    in_valid    = 1;
    instruction = {4'h6, 4'h3, 8'h00};
    data0       = 8'hFF;
    data1       = 8'hFF;
    @(posedge clk);
    @(negedge clk);
    in_valid = 0;
    repeat (3) @(posedge clk);
    #2 rst_n = 0;
    #1;
    model_reset();
    check_reset_state("mul_reset");
    repeat (2) @(negedge clk);
    rst_n = 1;
    idle_cycles(12);
    check("mul_reset_bus", out_bus, exp_bus());

    // Randomized ops
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 4) == 0) op = $urandom_range(8, 15);
      else op = $urandom_range(0, 7);
      run_op(op, $urandom_range(0, 15), $urandom_range(0, M - 1), $urandom_range(0, M - 1));
      if ($urandom_range(0, 3) == 0) idle_cycles($urandom_range(1, 2));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
